// File: rtl/mem_access_unit.sv
// Memory access controller: owns the MAR and runs one Read or Write at a time
// against a synchronous word-addressed RAM with a parameterised read latency.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MARin,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] MDR_q,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mdr_load,
    output logic              mem_done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] mar_q;
    logic              unused_bus_hi;

    // The MAR only keeps the low ADDR_W bits of the bus.
    assign unused_bus_hi = ^BusMuxOut[DATA_W-1:ADDR_W];
    assign ram_addr      = mar_q;

    // All strobes are registered alongside the state so nothing combinational
    // reaches them from the inputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mar_q     <= '0;
            Mdatain   <= '0;
            ram_wdata <= '0;
            mdr_load  <= 1'b0;
            mem_done  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            mdr_load <= 1'b0;
            mem_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (MARin) begin
                        mar_q <= BusMuxOut[ADDR_W-1:0];
                    end
                    if (Read && Write) begin
                        err <= 1'b1;
                    end else if (Read) begin
                        state_q <= StRd;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        ram_en  <= 1'b1;
                    end else if (Write) begin
                        state_q   <= StWr;
                        ram_wdata <= MDR_q;
                        busy      <= 1'b1;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                    end
                end
                StRd: begin
                    if (cnt_q == 4'd0) begin
                        Mdatain  <= ram_rdata;
                        state_q  <= StDone;
                        ram_en   <= 1'b0;
                        mem_done <= 1'b1;
                        mdr_load <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWr: begin
                    state_q  <= StDone;
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    mem_done <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
            // Requests or MAR loads outside IDLE are dropped and flagged.
            if (state_q != StIdle && (Read || Write || MARin)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: RAM models, expected read data queued at
// request time and checked when mdr_load fires.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        MARin = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0] BusMuxOut = '0, MDR_q = '0;
    logic        mar3 = 1'b0, rd3 = 1'b0, wr3 = 1'b0;
    logic        preload = 1'b0;

    logic [31:0] mdat1, wdata1, rdata1, mdat3, wdata3, rdata3;
    logic [8:0]  addr1, addr3;
    logic        load1, done1, busy1, err1, en1, we1;
    logic        load3, done3, busy3, err3, en3, we3;

    logic [31:0] ram1 [512];
    logic [31:0] ram3 [512];
    logic [31:0] p3 [3];
    logic [31:0] model [512];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .clr(clr), .MARin(MARin), .BusMuxOut(BusMuxOut), .Read(Read),
        .Write(Write), .MDR_q(MDR_q), .Mdatain(mdat1), .mdr_load(load1), .mem_done(done1),
        .busy(busy1), .err(err1), .ram_addr(addr1), .ram_wdata(wdata1), .ram_en(en1),
        .ram_we(we1), .ram_rdata(rdata1)
    );

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr), .MARin(mar3), .BusMuxOut(BusMuxOut), .Read(rd3),
        .Write(wr3), .MDR_q(MDR_q), .Mdatain(mdat3), .mdr_load(load3), .mem_done(done3),
        .busy(busy3), .err(err3), .ram_addr(addr3), .ram_wdata(wdata3), .ram_en(en3),
        .ram_we(we3), .ram_rdata(rdata3)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | (32'(i) * 32'h00010001));
    endfunction

    // Latency-1 RAM for dut1
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram1[i] <= init_val(i);
        end else if (en1) begin
            if (we1) ram1[addr1] <= wdata1;
            else     rdata1 <= ram1[addr1];
        end
    end

    // Latency-3 RAM for dut3
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram3[i] <= init_val(i);
        end else if (en3 && we3) begin
            ram3[addr3] <= wdata3;
        end
        p3[0] <= ram3[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after the request edge; waits for mem_done within a bound.
    task automatic wait_done(input int which, input int exp_lat, input logic exp_load,
                             input int exp_en, input string tag);
        int   lat = 0;
        int   en = 0;
        logic d;
        logic [31:0] exp;
        d = (which == 3) ? done3 : done1;
        while (!d && lat < 40) begin
            if ((which == 3) ? en3 : en1) en++;
            tick();
            lat++;
            d = (which == 3) ? done3 : done1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_en_cycles"}, en, exp_en);
        if (d) begin
            check({tag, "_mdr_load"}, 32'((which == 3) ? load3 : load1), 32'(exp_load));
            if (exp_load) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                check({tag, "_mdatain"}, (which == 3) ? mdat3 : mdat1, exp);
            end
            tick();
            check({tag, "_done_pulse"}, 32'((which == 3) ? done3 : done1), 32'd0);
            check({tag, "_idle"}, 32'((which == 3) ? busy3 : busy1), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) model[i] = init_val(i);
        preload = 1'b1;
        tick();
        tick();
        preload = 1'b0;
        check("rst_busy", 32'(busy1), 0);
        check("rst_err", 32'(err1), 0);
        check("rst_strobes", {28'd0, load1, done1, en1, we1}, 0);
        check("rst_addr", 32'(addr1), 0);
        check("rst_mdatain", mdat1, 0);
        check("rst_wdata", wdata1, 0);
        clr = 1'b1;
        tick();

        // Basic read at W=1
        BusMuxOut = 32'd5; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        check("mar_load", 32'(addr1), 32'd5);
        Read = 1'b1; exp_q.push_back(model[5]);
        tick();
        Read = 1'b0;
        check("rd_busy", 32'(busy1), 1);
        check("rd_en_we", {30'd0, en1, we1}, 32'd2);
        wait_done(1, 2, 1'b1, 2, "rd5");

        // Write to 0x1FF with MAR loaded on the same edge, then read back
        BusMuxOut = 32'h1FF; MARin = 1'b1; MDR_q = 32'h12345678; Write = 1'b1;
        tick();
        MARin = 1'b0; Write = 1'b0; model[9'h1FF] = 32'h12345678;
        check("wr_we", 32'(we1), 1);
        check("wr_addr", 32'(addr1), 32'h1FF);
        check("wr_wdata", wdata1, 32'h12345678);
        wait_done(1, 1, 1'b0, 1, "wr");
        check("wr_ram", ram1[9'h1FF], 32'h12345678);
        Read = 1'b1; exp_q.push_back(model[9'h1FF]);
        tick();
        Read = 1'b0;
        wait_done(1, 2, 1'b1, 2, "rdback");

        // Truncation and latency at W=3
        BusMuxOut = 32'hFFFF_FE07; mar3 = 1'b1;
        tick();
        mar3 = 1'b0;
        check("trunc_addr", 32'(addr3), 32'h007);
        rd3 = 1'b1; exp_q.push_back(model[7]);
        tick();
        rd3 = 1'b0;
        wait_done(3, 4, 1'b1, 4, "w3");

        // Read and Write together in IDLE
        Read = 1'b1; Write = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        check("rw_busy", 32'(busy1), 0);
        check("rw_err", 32'(err1), 1);
        tick();
        check("rw_still_idle", 32'(busy1), 0);
        clr = 1'b0;
        #1;
        check("rw_err_clr", 32'(err1), 0);
        tick();
        clr = 1'b1;

        // Write and MARin while a read is in flight
        BusMuxOut = 32'h20; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        Read = 1'b1; exp_q.push_back(model[9'h20]);
        tick();
        Read = 1'b0;
        Write = 1'b1; MARin = 1'b1; BusMuxOut = 32'h55;
        tick();
        Write = 1'b0; MARin = 1'b0;
        check("busy_err", 32'(err1), 1);
        check("busy_mar", 32'(addr1), 32'h20);
        wait_done(1, 1, 1'b1, 1, "rdbusy");
        tick();
        tick();
        check("err_sticky", 32'(err1), 1);
        check("mar_kept", 32'(addr1), 32'h20);
        clr = 1'b0;
        #1;
        check("err_cleared", 32'(err1), 0);
        tick();
        clr = 1'b1;

        // Reset in the middle of a write
        BusMuxOut = 32'h30; MARin = 1'b1; MDR_q = 32'hCAFEF00D; Write = 1'b1;
        tick();
        MARin = 1'b0; Write = 1'b0;
        check("abort_we_hi", 32'(we1), 1);
        #2 clr = 1'b0;
        #1;
        check("abort_we_async", 32'(we1), 0);
        check("abort_strobes", {27'd0, busy1, load1, done1, en1, err1}, 0);
        check("abort_addr", 32'(addr1), 0);
        check("abort_wdata", wdata1, 0);
        tick();
        check("abort_no_done", 32'(done1), 0);
        check("abort_ram", ram1[9'h30], model[9'h30]);
        clr = 1'b1;
        BusMuxOut = 32'h30; MARin = 1'b1; Read = 1'b1; exp_q.push_back(model[9'h30]);
        tick();
        MARin = 1'b0; Read = 1'b0;
        wait_done(1, 2, 1'b1, 2, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
